// File: rtl/sink_table_writer_if.sv
// sink_table_writer_if: shared 16-bit word-memory port
// address  : word address, byte-style (step 2), driven by the writer
// wr_en    : write strobe; address/data_out valid in the same cycle
// data_out : write data
// data_in  : read data for the address presented by the writer
interface sink_table_writer_if;
    logic [10:0] address;
    logic        wr_en;
    logic [15:0] data_out;
    logic [15:0] data_in;
    modport master (output address, output wr_en, output data_out, input data_in);
    modport slave  (input address, input wr_en, input data_out, output data_in);
endinterface

// File: rtl/sink_table_writer.sv
// sink_table_writer: inserts one neighbor advertisement into the neighbor and known-sink tables
// clock/rst        : clock (rising edge), synchronous active-high reset
// i_en, i_start    : enable and start request
// i_nbr_*          : advertised neighbor ID, cluster ID and sink flag
// mem              : shared word-memory port (master side)
// o_new_neighbor   : last operation appended a neighbor
// o_new_sink       : last operation appended a known sink
// o_table_full     : last operation dropped an append at capacity
// o_done           : one-cycle completion pulse
module sink_table_writer #(
    parameter int MAX_NEIGHBORS = 64,
    parameter int MAX_SINKS     = 32
) (
    input  logic                        clock,
    input  logic                        rst,
    input  logic                        i_en,
    input  logic                        i_start,
    input  logic [15:0]                 i_nbr_id,
    input  logic [15:0]                 i_nbr_cluster,
    input  logic                        i_nbr_is_sink,
    sink_table_writer_if.master         mem,
    output logic                        o_new_neighbor,
    output logic                        o_new_sink,
    output logic                        o_table_full,
    output logic                        o_done
);
    localparam logic [3:0] IDLE = 4'd0, RD_NCNT = 4'd1, SCAN_N = 4'd2, APPEND = 4'd3, SINK_CHK = 4'd4,
                           RD_SCNT = 4'd5, SCAN_S = 4'd6, APPEND_S = 4'd7, DONE = 4'd8;
    localparam logic [15:0] NMAX = 16'(MAX_NEIGHBORS);
    localparam logic [15:0] SMAX = 16'(MAX_SINKS);
    localparam logic [10:0] NCNT_A = 11'h68A, SCNT_A = 11'h688, NID_A = 11'h48, NCL_A = 11'hC8, SID_A = 11'h8;
    logic [3:0]  r_state;
    logic [1:0]  r_step;
    logic [15:0] r_i, r_j, r_ncount, r_scount, r_id, r_cluster, r_data_out;
    logic        r_sink, r_wr_en, r_done, r_new_n, r_new_s, r_full;
    logic [10:0] r_address;
    logic [15:0] w_i_nx, w_j_nx;
    assign w_i_nx = r_i + 16'd1;
    assign w_j_nx = r_j + 16'd1;
    assign mem.address = r_address;
    assign mem.wr_en = r_wr_en;
    assign mem.data_out = r_data_out;
    assign o_new_neighbor = r_new_n;
    assign o_new_sink = r_new_s;
    assign o_table_full = r_full;
    assign o_done = r_done;
    always_ff @(posedge clock) begin
        if (rst) begin
            r_state <= IDLE;
            r_step <= 2'd0;
            r_i <= 16'd0;
            r_j <= 16'd0;
            r_ncount <= 16'd0;
            r_scount <= 16'd0;
            r_id <= 16'd0;
            r_cluster <= 16'd0;
            r_sink <= 1'b0;
            r_address <= NCNT_A;
            r_data_out <= 16'd0;
            r_wr_en <= 1'b0;
            r_done <= 1'b0;
            r_new_n <= 1'b0;
            r_new_s <= 1'b0;
            r_full <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (i_start && i_en) begin
                    r_id <= i_nbr_id;
                    r_cluster <= i_nbr_cluster;
                    r_sink <= i_nbr_is_sink;
                    r_new_n <= 1'b0;
                    r_new_s <= 1'b0;
                    r_full <= 1'b0;
                    r_step <= 2'd0;
                    r_address <= NCNT_A;
                    r_state <= RD_NCNT;
                end
                RD_NCNT: begin
                    r_ncount <= mem.data_in;
                    r_i <= 16'd0;
                    if (mem.data_in == 16'd0) r_state <= APPEND;
                    else begin
                        r_address <= NID_A;
                        r_state <= SCAN_N;
                    end
                end
                // Scan is capped at capacity so an oversized stored count cannot run past the table
                SCAN_N: if (mem.data_in == r_id) begin
                    r_address <= NCL_A + {r_i[9:0], 1'b0};
                    r_data_out <= r_cluster;
                    r_wr_en <= 1'b1;
                    r_state <= SINK_CHK;
                end else begin
                    r_i <= w_i_nx;
                    if (w_i_nx == r_ncount || w_i_nx >= NMAX) r_state <= APPEND;
                    else r_address <= NID_A + {w_i_nx[9:0], 1'b0};
                end
                APPEND: if (r_ncount >= NMAX) begin
                    r_full <= 1'b1;
                    r_state <= SINK_CHK;
                end else begin
                    r_wr_en <= 1'b1;
                    r_step <= r_step + 2'd1;
                    r_address <= r_step == 2'd0 ? NID_A + {r_ncount[9:0], 1'b0} :
                                 r_step == 2'd1 ? NCL_A + {r_ncount[9:0], 1'b0} : NCNT_A;
                    r_data_out <= r_step == 2'd0 ? r_id : r_step == 2'd1 ? r_cluster : r_ncount + 16'd1;
                    if (r_step == 2'd2) begin
                        r_new_n <= 1'b1;
                        r_step <= 2'd0;
                        r_state <= SINK_CHK;
                    end
                end
                SINK_CHK: if (!r_sink) r_state <= DONE;
                else begin
                    r_address <= SCNT_A;
                    r_state <= RD_SCNT;
                end
                RD_SCNT: begin
                    r_scount <= mem.data_in;
                    r_j <= 16'd0;
                    if (mem.data_in == 16'd0) r_state <= APPEND_S;
                    else begin
                        r_address <= SID_A;
                        r_state <= SCAN_S;
                    end
                end
                SCAN_S: if (mem.data_in == r_id) r_state <= DONE;
                else begin
                    r_j <= w_j_nx;
                    if (w_j_nx == r_scount || w_j_nx >= SMAX) r_state <= APPEND_S;
                    else r_address <= SID_A + {w_j_nx[9:0], 1'b0};
                end
                APPEND_S: if (r_scount >= SMAX) begin
                    r_full <= 1'b1;
                    r_state <= DONE;
                end else begin
                    r_wr_en <= 1'b1;
                    r_step <= r_step + 2'd1;
                    r_address <= r_step == 2'd0 ? SID_A + {r_scount[9:0], 1'b0} : SCNT_A;
                    r_data_out <= r_step == 2'd0 ? r_id : r_scount + 16'd1;
                    if (r_step == 2'd1) begin
                        r_new_s <= 1'b1;
                        r_step <= 2'd0;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_done <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sink_table_writer.sv
// tb_sink_table_writer: randomized self-checking bench with a table-level reference model
module tb_sink_table_writer;
    logic clk = 1'b0, rst = 1'b1, i_en = 1'b0, i_start = 1'b0, i_nbr_is_sink = 1'b0, load = 1'b0;
    logic [15:0] i_nbr_id = 16'd0, i_nbr_cluster = 16'd0;
    logic o_new_neighbor, o_new_sink, o_table_full, o_done;
    logic [15:0] mem [0:1023];
    logic [15:0] ref_mem [0:1023];
    logic [26:0] wq[$];
    logic [26:0] exp_q[$];
    int wc[$];
    int cyc_n = 0;
    int vectors = 0, miscompares = 0;
    logic e_nn, e_ns, e_full;

    sink_table_writer_if bus();
    sink_table_writer dut (
        .clock(clk), .rst(rst), .i_en(i_en), .i_start(i_start),
        .i_nbr_id(i_nbr_id), .i_nbr_cluster(i_nbr_cluster), .i_nbr_is_sink(i_nbr_is_sink),
        .mem(bus), .o_new_neighbor(o_new_neighbor), .o_new_sink(o_new_sink),
        .o_table_full(o_table_full), .o_done(o_done)
    );

    always #5 clk = ~clk;
    assign bus.data_in = mem[bus.address[10:1]];

    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (load) begin
            for (int k = 0; k < 1024; k++) mem[k] <= ref_mem[k];
        end else if (bus.wr_en) begin
            mem[bus.address[10:1]] <= bus.data_out;
            wq.push_back({bus.address, bus.data_out});
            wc.push_back(cyc_n);
        end
    end

    task automatic sync_mem();
        @(negedge clk) load = 1'b1;
        @(negedge clk) load = 1'b0;
    endtask

    task automatic clear_ref();
        for (int k = 0; k < 1024; k++) ref_mem[k] = 16'd0;
    endtask

    task automatic put(input int a, input logic [15:0] d);
        logic [10:0] a11;
        a11 = a[10:0];
        exp_q.push_back({a11, d});
        ref_mem[a11[10:1]] = d;
    endtask

    task automatic look(input int cnt_a, input int base, input int cap, input logic [15:0] id,
                        output logic hit, output int cnt, output int idx);
        cnt = int'(ref_mem[cnt_a / 2]);
        hit = 1'b0;
        idx = 0;
        for (int k = 0; k < (cnt < cap ? cnt : cap); k++)
            if (!hit && ref_mem[base / 2 + k] == id) begin
                hit = 1'b1;
                idx = k;
            end
    endtask

    task automatic model_op(input logic [15:0] id, input logic [15:0] cl, input logic s);
        logic hit;
        int cnt, idx;
        exp_q.delete();
        e_nn = 1'b0;
        e_ns = 1'b0;
        e_full = 1'b0;
        look(32'h68A, 32'h48, 64, id, hit, cnt, idx);
        if (hit) put(32'hC8 + 2 * idx, cl);
        else if (cnt >= 64) e_full = 1'b1;
        else begin
            put(32'h48 + 2 * cnt, id);
            put(32'hC8 + 2 * cnt, cl);
            put(32'h68A, 16'(cnt + 1));
            e_nn = 1'b1;
        end
        if (s) begin
            look(32'h688, 32'h8, 32, id, hit, cnt, idx);
            if (!hit) begin
                if (cnt >= 32) e_full = 1'b1;
                else begin
                    put(32'h8 + 2 * cnt, id);
                    put(32'h688, 16'(cnt + 1));
                    e_ns = 1'b1;
                end
            end
        end
    endtask

    task automatic run_op(input string name, input logic [15:0] id, input logic [15:0] cl, input logic s);
        int cyc, bad;
        model_op(id, cl, s);
        wq.delete();
        wc.delete();
        @(negedge clk);
        i_en = 1'b1; i_start = 1'b1; i_nbr_id = id; i_nbr_cluster = cl; i_nbr_is_sink = s;
        @(negedge clk);
        i_start = 1'b0; i_nbr_id = ~id; i_nbr_cluster = 16'($urandom); i_nbr_is_sink = ~s; i_en = 1'($urandom);
        cyc = 0;
        while (!o_done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (!o_done) begin
            miscompares++;
            $display("FAIL %s done_timeout: no done after %0d cycles, required within 400", name, cyc);
        end
        vectors++;
        if (wq.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL %s write_count: got %0d required %0d", name, wq.size(), exp_q.size());
        end else
            for (int k = 0; k < wq.size(); k++) begin
                vectors++;
                if (wq[k] !== exp_q[k]) begin
                    miscompares++;
                    $display("FAIL %s write%0d: got addr %h data %h required addr %h data %h",
                             name, k, wq[k][26:16], wq[k][15:0], exp_q[k][26:16], exp_q[k][15:0]);
                end
            end
        vectors++;
        if ({o_new_neighbor, o_new_sink, o_table_full} !== {e_nn, e_ns, e_full}) begin
            miscompares++;
            $display("FAIL %s flags(nn,ns,full): got %b%b%b required %b%b%b", name,
                     o_new_neighbor, o_new_sink, o_table_full, e_nn, e_ns, e_full);
        end
        @(negedge clk);
        vectors++;
        if (o_done !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done_width: done still %b one cycle later, required 0", name, o_done);
        end
        bad = 0;
        for (int k = 0; k < 1024; k++) if (mem[k] !== ref_mem[k]) bad++;
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL %s memory: %0d words differ from reference, required 0", name, bad);
        end
        i_en = 1'b1;
    endtask

    task automatic check_run(input string name, input int first, input int n);
        vectors++;
        if (wc.size() < first + n || wc[first + n - 1] - wc[first] != n - 1) begin
            miscompares++;
            $display("FAIL %s consecutive: writes %0d..%0d not on consecutive cycles (got %0d writes)",
                     name, first, first + n - 1, wc.size());
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({bus.address, bus.wr_en, bus.data_out, o_done, o_new_neighbor, o_new_sink, o_table_full} !==
            {11'h68A, 1'b0, 16'h0, 4'b0}) begin
            miscompares++;
            $display("FAIL reset: got addr %h wr %b data %h done %b flags %b%b%b required 68a 0 0000 0 000",
                     bus.address, bus.wr_en, bus.data_out, o_done, o_new_neighbor, o_new_sink, o_table_full);
        end
        rst = 1'b0;
    endtask

    task automatic test_empty_append();
        clear_ref();
        sync_mem();
        run_op("empty_append", 16'h0005, 16'h0002, 1'b0);
        check_run("empty_append", 0, 3);
    endtask

    task automatic test_cluster_update();
        clear_ref();
        ref_mem[16'h48 >> 1] = 16'd3; ref_mem[16'h4A >> 1] = 16'd5; ref_mem[16'h4C >> 1] = 16'd9;
        ref_mem[16'h68A >> 1] = 16'd3;
        sync_mem();
        run_op("cluster_update", 16'd5, 16'd7, 1'b0);
    endtask

    task automatic test_sink_append();
        clear_ref();
        sync_mem();
        run_op("sink_append", 16'h000A, 16'd1, 1'b1);
        check_run("sink_append", 3, 2);
        run_op("sink_dup", 16'h000A, 16'd1, 1'b1);
    endtask

    task automatic test_full();
        clear_ref();
        ref_mem[16'h68A >> 1] = 16'd64;
        for (int k = 0; k < 64; k++) ref_mem[16'h24 + k] = 16'(16'h100 + k);
        sync_mem();
        run_op("nbr_full", 16'h0077, 16'd3, 1'b0);
        ref_mem[16'h688 >> 1] = 16'd32;
        for (int k = 0; k < 32; k++) ref_mem[4 + k] = 16'(16'h200 + k);
        sync_mem();
        run_op("sink_full", 16'h0078, 16'd3, 1'b1);
        ref_mem[16'h68A >> 1] = 16'd70;
        ref_mem[16'h688 >> 1] = 16'd40;
        sync_mem();
        run_op("over_capacity", 16'h0079, 16'd4, 1'b1);
    endtask

    task automatic test_reset_mid_scan();
        int seen;
        clear_ref();
        ref_mem[16'h68A >> 1] = 16'd40;
        for (int k = 0; k < 40; k++) ref_mem[16'h24 + k] = 16'(16'h300 + k);
        sync_mem();
        wq.delete();
        @(negedge clk);
        i_en = 1'b1; i_start = 1'b1; i_nbr_id = 16'h0001; i_nbr_cluster = 16'h0002; i_nbr_is_sink = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.wr_en, o_done, bus.address} !== {2'b00, 11'h68A}) begin
            miscompares++;
            $display("FAIL mid_scan_reset: got wr %b done %b addr %h required 0 0 68a", bus.wr_en, o_done, bus.address);
        end
        rst = 1'b0;
        i_en = 1'b0; i_start = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (o_done) seen++;
        end
        i_start = 1'b0; i_en = 1'b1;
        vectors++;
        if (seen != 0 || wq.size() != 0 || bus.address !== 11'h68A) begin
            miscompares++;
            $display("FAIL start_while_disabled: got %0d done pulses %0d writes addr %h required 0 0 68a",
                     seen, wq.size(), bus.address);
        end
    endtask

    task automatic test_back_to_back();
        clear_ref();
        sync_mem();
        run_op("b2b_a", 16'h0011, 16'h0021, 1'b1);
        run_op("b2b_b", 16'h0012, 16'h0022, 1'b1);
        run_op("b2b_c", 16'h0011, 16'h0023, 1'b1);
    endtask

    task automatic test_random();
        int n, s;
        for (int r = 0; r < 5; r++) begin
            clear_ref();
            n = $urandom_range(0, 66);
            s = $urandom_range(0, 34);
            ref_mem[16'h68A >> 1] = 16'(n);
            ref_mem[16'h688 >> 1] = 16'(s);
            for (int k = 0; k < 64; k++) ref_mem[16'h24 + k] = 16'($urandom_range(0, 15));
            for (int k = 0; k < 64; k++) ref_mem[16'h64 + k] = 16'($urandom);
            for (int k = 0; k < 32; k++) ref_mem[4 + k] = 16'($urandom_range(0, 15));
            sync_mem();
            repeat (8) run_op("random", 16'($urandom_range(0, 20)), 16'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_empty_append();
        test_cluster_update();
        test_sink_append();
        test_full();
        test_reset_mid_scan();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
